// File: rtl/mem_fifo.sv
// mem_fifo: synchronous FIFO with block-RAM style registered read data and sticky error flag.
// Defining FIFO_COUNT_EN adds the occupancy output port count.
module mem_fifo #(
  parameter int WIDTH    = 16,
  parameter int ADDR_W   = 5,
  parameter int AF_LEVEL = 2**ADDR_W - 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             err
`ifdef FIFO_COUNT_EN
  ,
  output logic [ADDR_W:0]  count
`endif
);

  localparam logic [ADDR_W:0] AF_LVL  = (ADDR_W+1)'(AF_LEVEL);
  localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [2**ADDR_W];

  logic [ADDR_W:0]  wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]  rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             err_q, err_d;
  logic [ADDR_W:0]  occ;
  logic             push_ok;
  logic             pop_ok;

  // Status flags decoded from the registered pointers only
  always_comb begin
    occ         = wr_ptr_q - rd_ptr_q;
    full        = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                  (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
    empty       = (wr_ptr_q == rd_ptr_q);
    almost_full = (occ >= AF_LVL);
  end

  // Acceptance, pointer advance, read data and sticky error next-state
  always_comb begin
    push_ok  = push & ~full;
    pop_ok   = pop & ~empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    dout_d   = dout_q;
    err_d    = err_q | (push & full) | (pop & empty);
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
      dout_d   = mem[rd_ptr_q[ADDR_W-1:0]];
    end else begin
      rd_ptr_d = rd_ptr_q;
      dout_d   = dout_q;
    end
  end

  // Control state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= {(ADDR_W+1){1'b0}};
      rd_ptr_q <= {(ADDR_W+1){1'b0}};
      dout_q   <= {WIDTH{1'b0}};
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      dout_q   <= dout_d;
      err_q    <= err_d;
    end
  end

  // Storage write port; contents survive reset but reset blocks the write
  always_ff @(posedge clk) begin
    if (rst_n && push_ok) begin
      mem[wr_ptr_q[ADDR_W-1:0]] <= din;
    end
  end

  assign dout = dout_q;
  assign err  = err_q;

`ifdef FIFO_COUNT_EN
  assign count = occ;
`endif

endmodule

// File: tb/tb_mem_fifo.sv
// tb_mem_fifo: directed self-checking bench for mem_fifo using a queue scoreboard.
// Define FIFO_COUNT_EN for both files to also check the count port.
module tb_mem_fifo;

  localparam int WIDTH  = 16;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;
  localparam int AF     = 28;

  logic             clk;
  logic             rst_n;
  logic             push;
  logic [WIDTH-1:0] din;
  logic             pop;
  logic [WIDTH-1:0] dout;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             err;
`ifdef FIFO_COUNT_EN
  logic [ADDR_W:0]  count;
`endif

  mem_fifo #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .AF_LEVEL(AF)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (push),
    .din         (din),
    .pop         (pop),
    .dout        (dout),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .err         (err)
`ifdef FIFO_COUNT_EN
    ,
    .count       (count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [WIDTH-1:0] sb[$];
  logic [WIDTH-1:0] exp_dout;
  logic             exp_err;
  int               n_assert;
  int               n_fail;
  string            phase;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s/%s: observed %0h expected %0h", phase, tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("dout",        32'(dout),        32'(exp_dout));
    chk("empty",       32'(empty),       32'(sb.size() == 0));
    chk("full",        32'(full),        32'(sb.size() == DEPTH));
    chk("almost_full", 32'(almost_full), 32'(sb.size() >= AF));
    chk("err",         32'(err),         32'(exp_err));
`ifdef FIFO_COUNT_EN
    chk("count",       32'(count),       32'(sb.size()));
`endif
  endtask

  // One clock cycle: drive inputs, update the model at the edge, check after it.
  task automatic cyc(input logic p, input logic [WIDTH-1:0] d, input logic q);
    int occ_before;
    occ_before = sb.size();
    push = p;
    din  = d;
    pop  = q;
    @(posedge clk);
    if (!rst_n) begin
      sb.delete();
      exp_dout = '0;
      exp_err  = 1'b0;
    end else begin
      if (q && occ_before > 0) exp_dout = sb.pop_front();
      if (p && occ_before < DEPTH) sb.push_back(d);
      if ((p && occ_before == DEPTH) || (q && occ_before == 0)) exp_err = 1'b1;
    end
    #1;
    push = 1'b0;
    pop  = 1'b0;
    check_all();
  endtask

  task automatic do_reset(input logic p);
    rst_n = 1'b0;
    cyc(p, 16'h5A5A, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    exp_dout = '0;
    exp_err  = 1'b0;
    rst_n    = 1'b0;
    push     = 1'b0;
    pop      = 1'b0;
    din      = '0;

    phase = "reset";
    @(posedge clk);
    do_reset(1'b0);

    phase = "fill";
    for (int i = 1; i <= DEPTH; i++) cyc(1'b1, WIDTH'(i), 1'b0);

    phase = "drain";
    for (int i = 0; i < DEPTH; i++) cyc(1'b0, 16'h0000, 1'b1);

    phase = "underflow";
    cyc(1'b0, 16'h0000, 1'b1);
    cyc(1'b1, 16'hABCD, 1'b0);
    cyc(1'b0, 16'h0000, 1'b1);

    phase = "full_push_pop";
    do_reset(1'b0);
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, WIDTH'(16'h1000 + i), 1'b0);
    cyc(1'b1, 16'hDEAD, 1'b1);
    for (int i = 0; i < DEPTH - 1; i++) cyc(1'b0, 16'h0000, 1'b1);

    phase = "occ1_push_pop";
    do_reset(1'b0);
    cyc(1'b1, 16'h0100, 1'b0);
    for (int i = 1; i <= 3; i++) cyc(1'b1, WIDTH'(16'h0100 + i), 1'b1);
    cyc(1'b0, 16'h0000, 1'b1);

    phase = "wrap";
    do_reset(1'b0);
    for (int i = 0; i < 8; i++) cyc(1'b1, WIDTH'(16'h2000 + i), 1'b0);
    for (int i = 8; i < 40; i++) cyc(1'b1, WIDTH'(16'h2000 + i), 1'b1);
    for (int i = 0; i < 8; i++) cyc(1'b0, 16'h0000, 1'b1);
    cyc(1'b0, 16'h0000, 1'b1);

    phase = "mid_reset";
    do_reset(1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b1, WIDTH'(16'h3000 + i), 1'b0);
    cyc(1'b0, 16'h0000, 1'b1);
    do_reset(1'b1);
    cyc(1'b1, 16'h7777, 1'b0);
    cyc(1'b0, 16'h0000, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
